// File: rtl/cache_controller.sv
// Two-way set-associative, one-word-per-line, write-through / no-write-allocate
// data cache sitting between the MEM stage and a level-held SRAM controller.
module cache_controller #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                sram_rd_en_reg;
  logic                sram_wr_en_reg;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          way_hit;
  logic [1:0]          way_valid;
  logic [1:0]          way_we;
  logic [1:0][31:0]    way_data;
  logic [31:0]         line_wdata;
  logic [SETS-1:0]     lru_reg;
  logic                lru_we;
  logic                lru_next;
  logic                hit;
  logic                hit_way;
  logic                victim;
  logic                unused_addr;

  assign index        = address[2 +: INDEX_W];
  assign tag          = address[INDEX_W+2 +: TAG_W];
  assign unused_addr  = ^address[1:0];
  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign sram_rd_en   = sram_rd_en_reg;
  assign sram_wr_en   = sram_wr_en_reg;

  // Each way keeps its own valid/tag/data storage; reads are asynchronous
  // because hits must complete in the same cycle as the request.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [SETS-1:0]  valid_reg;
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [31:0]      data_mem [SETS];

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= '0;
        end else if (way_we[gi]) begin
          valid_reg[index] <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst && way_we[gi]) begin
          tag_mem[index]  <= tag;
          data_mem[index] <= line_wdata;
        end
      end

      assign way_valid[gi] = valid_reg[index];
      assign way_hit[gi]   = valid_reg[index] && (tag_mem[index] == tag);
      assign way_data[gi]  = data_mem[index];
    end
  endgenerate

  assign hit     = |way_hit;
  assign hit_way = way_hit[1];
  assign victim  = !way_valid[0] ? 1'b0 :
                   !way_valid[1] ? 1'b1 : lru_reg[index];

  // lru names the way to replace next, so it points away from the accessed way.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b1;
    rdata      = '0;
    way_we     = '0;
    line_wdata = wdata;
    lru_we     = 1'b0;
    lru_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_w_en) begin
          ready      = 1'b0;
          state_next = WRITE;
          if (hit) begin
            way_we   = way_hit;
            lru_we   = 1'b1;
            lru_next = ~hit_way;
          end
        end else if (mem_r_en) begin
          if (hit) begin
            rdata    = hit_way ? way_data[1] : way_data[0];
            lru_we   = 1'b1;
            lru_next = ~hit_way;
          end else begin
            ready      = 1'b0;
            state_next = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        ready = sram_ready;
        if (sram_ready) begin
          rdata          = sram_rdata;
          line_wdata     = sram_rdata;
          way_we[victim] = 1'b1;
          lru_we         = 1'b1;
          lru_next       = ~victim;
          state_next     = IDLE;
        end
      end
      WRITE: begin
        ready = sram_ready;
        if (sram_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lru_reg <= '0;
    end else if (lru_we) begin
      lru_reg[index] <= lru_next;
    end
  end

  // SRAM enables come straight from the registered next state, so they drop
  // in the cycle after sram_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sram_rd_en_reg <= 1'b0;
      sram_wr_en_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sram_rd_en_reg <= (state_next == READ_MISS);
      sram_wr_en_reg <= (state_next == WRITE);
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: the bench acts as the SRAM controller and predicts every
// access with an LRU-ordered per-set model of the cache contents.
module tb_cache_controller;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 24;
  localparam int SETS    = 1 << INDEX_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  cache_controller #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic [31:0] waits;
    logic [31:0] rd;
    logic        sram_used;
    logic        proto_ok;
  } result_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] lat;
  } op_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Backing SRAM contents and the cache model (entry 0 = most recently used).
  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] set_addr [SETS][2];
  logic [31:0] set_data [SETS][2];
  int          set_cnt  [SETS];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SETS; i++) set_cnt[i] = 0;
  endfunction

  function automatic result_t predict(input logic wr, input logic [31:0] a,
                                      input logic [31:0] wd, input int lat);
    result_t     e;
    int          s;
    int          pos;
    logic [31:0] ta;
    logic [31:0] td;
    e = '0;
    e.done = 1'b1;
    e.proto_ok = 1'b1;
    s = int'(a[INDEX_W+1:2]);
    pos = -1;
    for (int i = 0; i < set_cnt[s]; i++) if (set_addr[s][i] == a) pos = i;
    if (pos >= 0) begin
      if (wr) set_data[s][pos] = wd;
      e.rd = wr ? 32'h0 : set_data[s][pos];
      if (pos == 1) begin
        ta = set_addr[s][0]; td = set_data[s][0];
        set_addr[s][0] = set_addr[s][1]; set_data[s][0] = set_data[s][1];
        set_addr[s][1] = ta; set_data[s][1] = td;
      end
    end
    if (wr || pos < 0) begin
      e.waits = lat;
      e.sram_used = 1'b1;
    end
    if (!wr && pos < 0) begin
      e.rd = mem_rd(a);
      if (set_cnt[s] < 2) set_cnt[s]++;
      set_addr[s][1] = set_addr[s][0]; set_data[s][1] = set_data[s][0];
      set_addr[s][0] = a;              set_data[s][0] = e.rd;
    end
    return e;
  endfunction

  // Presents one MEM-stage request and plays the SRAM controller until ready.
  task automatic drive(input logic wr, input logic both, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, output result_t r);
    int   held;
    logic req;
    r = '0;
    r.proto_ok = 1'b1;
    held = 0;
    for (int c = 0; c < 64 && !r.done; c++) begin
      @(negedge clk);
      mem_r_en = !wr || both;
      mem_w_en = wr;
      address  = a;
      wdata    = wd;
      sram_ready = 1'b0;
      #1;
      req = sram_rd_en | sram_wr_en;
      if (c == 0 && req) r.proto_ok = 1'b0;
      if (req) begin
        held++;
        r.sram_used = 1'b1;
        if (sram_address !== a || sram_rd_en !== ~wr || sram_wr_en !== wr ||
            (wr && sram_wdata !== wd)) r.proto_ok = 1'b0;
      end
      sram_rdata = $urandom;
      sram_ready = req && (held == lat);
      if (sram_ready && !wr) sram_rdata = mem_rd(a);
      if (sram_ready && wr) sram_mem[a] = wd;
      #1;
      if (ready === 1'b1) begin
        r.rd = rdata;
        r.done = 1'b1;
      end else begin
        r.waits = r.waits + 1;
        if (rdata !== 32'h0) r.proto_ok = 1'b0;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_ops(input string name, input op_t ops [], input logic both);
    result_t e;
    result_t r;
    foreach (ops[i]) begin
      e = predict(ops[i].wr, ops[i].addr, ops[i].wd, int'(ops[i].lat));
      drive(ops[i].wr, both, ops[i].addr, ops[i].wd, int'(ops[i].lat), r);
      total_cnt++;
      if (r !== e)
        $display("FAIL %s[%0d] wr=%0d addr=%h: got done=%0d waits=%0d rd=%h sram=%0d proto=%0d, expected done=%0d waits=%0d rd=%h sram=%0d proto=%0d",
                 name, i, ops[i].wr, ops[i].addr, r.done, r.waits, r.rd, r.sram_used, r.proto_ok,
                 e.done, e.waits, e.rd, e.sram_used, e.proto_ok);
      else begin
        pass_cnt++;
        $display("txn %s[%0d] wr=%0d addr=%h wd=%h lat=%0d waits=%0d rd=%h sram=%0d",
                 name, i, ops[i].wr, ops[i].addr, ops[i].wd, ops[i].lat, r.waits, r.rd, r.sram_used);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else pass_cnt++;
    total_cnt++;
    if (sram_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", sram_rd_en); else pass_cnt++;
    total_cnt++;
    if (sram_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", sram_wr_en); else pass_cnt++;
    total_cnt++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else pass_cnt++;
  endtask

  task automatic test_read_miss_hit();
    op_t ops [];
    sram_mem[32'h400] = 32'hDEAD_BEEF;
    ops = '{'{1'b0, 32'h400, 32'h0, 32'd6}, '{1'b0, 32'h400, 32'h0, 32'd6}};
    run_ops("read_miss_hit", ops, 1'b0);
  endtask

  task automatic test_write_hit();
    op_t ops [];
    ops = '{'{1'b1, 32'h400, 32'h1234_5678, 32'd3}, '{1'b0, 32'h400, 32'h0, 32'd2}};
    run_ops("write_hit", ops, 1'b0);
  endtask

  task automatic test_conflict();
    op_t ops [];
    do_reset();
    ops = '{'{1'b0, 32'h400, 32'h0, 32'd2}, '{1'b0, 32'h500, 32'h0, 32'd3},
            '{1'b0, 32'h400, 32'h0, 32'd1}, '{1'b0, 32'h600, 32'h0, 32'd2},
            '{1'b0, 32'h400, 32'h0, 32'd1}, '{1'b0, 32'h500, 32'h0, 32'd4}};
    run_ops("conflict", ops, 1'b0);
  endtask

  task automatic test_write_miss();
    op_t ops [];
    ops = '{'{1'b1, 32'h700, 32'hCAFE_F00D, 32'd2}, '{1'b0, 32'h700, 32'h0, 32'd3}};
    run_ops("write_miss", ops, 1'b1);
  endtask

  task automatic test_reset_mid();
    op_t ops [];
    do_reset();
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'h400; sram_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (sram_rd_en !== 1'b1) $display("FAIL pend_rd_en: got %b expected 1", sram_rd_en); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_r_en = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (sram_rd_en !== 1'b0) $display("FAIL abort_rd_en: got %b expected 0", sram_rd_en); else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready); else pass_cnt++;
    ops = '{'{1'b0, 32'h400, 32'h0, 32'd2}};
    run_ops("reset_mid", ops, 1'b0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      go_idle();
      #1;
      total_cnt++;
      if (ready !== 1'b1 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || rdata !== 32'h0)
        $display("FAIL idle[%0d]: got ready=%b rd_en=%b wr_en=%b rdata=%h expected 1 0 0 0",
                 i, ready, sram_rd_en, sram_wr_en, rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_traffic();
    op_t ops [];
    op_t o;
    ops = new[200];
    foreach (ops[i]) begin
      o.wr   = ($urandom_range(0, 9) < 3);
      o.addr = (32'($urandom_range(1, 5)) << (INDEX_W + 2)) | (32'($urandom_range(0, 2)) << 2);
      o.wd   = $urandom;
      o.lat  = 32'($urandom_range(1, 4));
      ops[i] = o;
    end
    run_ops("random", ops, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_conflict();
    test_write_miss();
    test_reset_mid();
    test_idle();
    test_random_traffic();
    go_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
